// File: rtl/uart_tx_fifo_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_pkg
// Shared definitions for the buffered UART transmit front-end:
//   - default character width and FIFO address width
//   - derived FIFO depth
//   - drain FSM state encoding (2-bit)
//   - helper to build the "full" occupancy value for a given address width
// ----------------------------------------------------------------------------
package uart_tx_fifo_pkg;

    localparam int DBITS_DEFAULT      = 8;
    localparam int ADDR_WIDTH_DEFAULT = 4;
    localparam int DEPTH              = 2 ** ADDR_WIDTH_DEFAULT;

    // Drain FSM encoding; kept explicit so checkers can decode the debug port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Occupancy value that means "full" for a FIFO of 2**aw entries.
    function automatic int depth_of(input int aw);
        return 2 ** aw;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_if
// Bundles the host-side write port, FIFO status, and the UART_tx handshake.
//
// Handshake semantics (the one place they are written down):
//   - wr_en/wr_data: single-cycle strobe, no ready. A strobe is accepted when
//     the FIFO is not full, or when it is full but a pop happens the same
//     cycle. A dropped strobe raises overflow for exactly one cycle,
//     visible after the edge that dropped it.
//   - tx_start/tx_din: tx_start is a one-cycle pulse; tx_din is registered
//     and held stable from the start pulse until the transfer completes.
//   - tx_done_tick: one-cycle completion pulse from UART_tx; only meaningful
//     while busy is high.
//
// Modports:
//   master : host / UART-side environment (drives wr_en, wr_data, tx_done_tick)
//   slave  : uart_tx_fifo (drives status, tx_din, tx_start, busy, state)
// ----------------------------------------------------------------------------
interface uart_tx_fifo_if
    import uart_tx_fifo_pkg::*;
#(
    parameter int DBITS      = DBITS_DEFAULT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
);
    logic                  wr_en;
    logic [DBITS-1:0]      wr_data;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  busy;
    logic [DBITS-1:0]      tx_din;
    logic                  tx_start;
    logic                  tx_done_tick;
    state_t                state;   // debug view of the drain FSM

    modport master (
        output wr_en, wr_data, tx_done_tick,
        input  full, empty, count, overflow, busy, tx_din, tx_start, state
    );

    modport slave (
        input  wr_en, wr_data, tx_done_tick,
        output full, empty, count, overflow, busy, tx_din, tx_start, state
    );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Generic single-clock FIFO with explicit occupancy counter. Reused for both
// the TX buffer and the RX-side buffer.
//
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   push         : write request (dropped when full unless pop is accepted)
//   wr_data      : data to write
//   pop          : read request (ignored when empty)
//   rd_data      : head entry, combinational from mem[rd_ptr]
//   full, empty  : combinational from count
//   count        : occupancy, 0..2**ADDR_WIDTH
//   overflow     : registered one-cycle pulse for a dropped push
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DBITS      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DBITS-1:0]      wr_data,
    input  logic                  pop,
    output logic [DBITS-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);
    localparam int             DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DBITS-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a push at full is still
    // accepted when it coincides with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage is not reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && full && !do_pop;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// Buffered transmit front-end placed directly upstream of UART_tx. Host bytes
// are queued in a sync_fifo; a three-state drain FSM hands them to UART_tx one
// at a time and waits for tx_done_tick before fetching the next.
//
// Ports:
//   clk   : rising-edge system clock
//   reset : synchronous active-high reset; drops in-flight and queued bytes
//   bus   : uart_tx_fifo_if.slave
//             wr_en, wr_data          host write strobe and byte
//             full, empty, count      FIFO status
//             overflow                one-cycle pulse for a dropped write
//             busy                    byte handed to UART_tx, not yet done
//             tx_din, tx_start        registered byte and start pulse
//             tx_done_tick            completion pulse from UART_tx
//             state                   drain FSM state (debug)
// ----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DBITS      = DBITS_DEFAULT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);
    state_t              state;
    logic                pop;
    logic [DBITS-1:0]    head;
    logic                fifo_empty;
    logic                fifo_full;
    logic [ADDR_WIDTH:0] fifo_count;
    logic                fifo_overflow;
    logic [DBITS-1:0]    tx_din_q;
    logic                tx_start_q;
    logic                busy_q;

    sync_fifo #(
        .DBITS      (DBITS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (bus.wr_en),
        .wr_data  (bus.wr_data),
        .pop      (pop),
        .rd_data  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (fifo_overflow)
    );

    // The pop is decided in IDLE from the current occupancy, so it is always
    // against a non-empty FIFO and never races a write to the same slot.
    assign pop = (state == ST_IDLE) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            tx_din_q   <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_start_q <= 1'b0;
                    if (!fifo_empty) begin
                        tx_din_q   <= head;
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    tx_start_q <= 1'b0;
                    // A completion this early still counts; do not wait for
                    // a second tick that will never come.
                    if (bus.tx_done_tick) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.tx_done_tick) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    tx_start_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.count    = fifo_count;
    assign bus.overflow = fifo_overflow;
    assign bus.busy     = busy_q;
    assign bus.tx_din   = tx_din_q;
    assign bus.tx_start = tx_start_q;
    assign bus.state    = state;
endmodule
